quan_pipe: RTL and testbench

Multi-channel, pipelined requantizer that turns signed convolution accumulator values into unsigned activation bytes, computing dout = sat(round(din × M0 / 2^shift) + zero_point). It keeps a separate M0/shift/zero_point set for each channel, accepts one beat per cycle over a valid/ready stream and is fully backpressure-aware. It sits between the PE-array accumulator output and the activation write-back buffer, and is the parametrised successor of the single-channel, free-running quantizer.

---
 rtl/quan_pipe.sv | 203 ++++++++++++++++++++
 tb/tb_quan_pipe.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/quan_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : quan_pipe
//  Purpose  : Multi-channel pipelined requantizer. Converts signed accumulator
//             values into unsigned activation bytes:
//                dout = sat(round(din * M0 / 2^shift) + zero_point)
//             Each channel has its own {m0, shift, zp} set. Input and output
//             are valid/ready streams and the pipeline stalls as a whole.
//  Build    : QUAN_ROUND_EN defined   -> round half up (bias = 2^(shift-1))
//             QUAN_ROUND_EN undefined -> floor (bias = 0)
//  Ports    : clk, rst_n (synchronous, active low)
//             cfg_we/cfg_ch/cfg_m0/cfg_shift/cfg_zp : parameter-set write
//             in_valid/in_ready/din/din_ch          : input stream
//             out_valid/out_ready/dout/dout_ch/dout_sat : output stream
//  Latency  : a beat accepted at edge k is presented after edge k+3
//  Revision : 1.0 - initial release
// ============================================================================
module quan_pipe #(
   parameter int DIN_W   = 18,
   parameter int M0_W    = 16,
   parameter int SHIFT_W = 4,
   parameter int DOUT_W  = 8,
   parameter int CH      = 4,
   parameter int CH_W    = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cfg_we,
   input  logic [CH_W-1:0]    cfg_ch,
   input  logic [M0_W-1:0]    cfg_m0,
   input  logic [SHIFT_W-1:0] cfg_shift,
   input  logic [DOUT_W-1:0]  cfg_zp,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DIN_W-1:0]   din,
   input  logic [CH_W-1:0]    din_ch,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DOUT_W-1:0]  dout,
   output logic [CH_W-1:0]    dout_ch,
   output logic               dout_sat
);

   // Product width: signed din times zero-extended (positive) m0, exact.
   localparam int PW = DIN_W + M0_W + 1;
   // Rounding/zero-point width: two guard bits so bias and zp adds never wrap.
   localparam int RW = PW + 2;
   localparam logic signed [RW-1:0] MAXV = RW'((1 << DOUT_W) - 1);

   // ---------------------------------------------------------------------
   // Per-channel parameter tables
   // ---------------------------------------------------------------------
   logic [M0_W-1:0]    m0_tab    [CH];
   logic [SHIFT_W-1:0] shift_tab [CH];
   logic [DOUT_W-1:0]  zp_tab    [CH];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < CH; i++) begin
            m0_tab[i]    <= M0_W'(1);
            shift_tab[i] <= '0;
            zp_tab[i]    <= '0;
         end
      end else if (cfg_we && (32'(cfg_ch) < CH)) begin
         m0_tab[cfg_ch]    <= cfg_m0;
         shift_tab[cfg_ch] <= cfg_shift;
         zp_tab[cfg_ch]    <= cfg_zp;
      end
   end

   // Parameter lookup for the incoming beat. The tables are read before any
   // same-edge write lands, so a racing write only affects later beats.
   logic [M0_W-1:0]    m0_sel;
   logic [SHIFT_W-1:0] shift_sel;
   logic [DOUT_W-1:0]  zp_sel;

   always_comb begin
      m0_sel    = M0_W'(1);
      shift_sel = '0;
      zp_sel    = '0;
      if (32'(din_ch) < CH) begin
         m0_sel    = m0_tab[din_ch];
         shift_sel = shift_tab[din_ch];
         zp_sel    = zp_tab[din_ch];
      end
   end

   // ---------------------------------------------------------------------
   // Handshake: the whole pipeline moves together
   // ---------------------------------------------------------------------
   logic adv;
   assign adv      = ~out_valid | out_ready;
   assign in_ready = adv;

   // ---------------------------------------------------------------------
   // Stage registers
   // ---------------------------------------------------------------------
   logic                     s1_valid;
   logic signed [DIN_W-1:0]  s1_din;
   logic [CH_W-1:0]          s1_ch;
   logic [M0_W-1:0]          s1_m0;
   logic [SHIFT_W-1:0]       s1_shift;
   logic [DOUT_W-1:0]        s1_zp;

   logic                     s2_valid;
   logic signed [PW-1:0]     s2_p;
   logic [CH_W-1:0]          s2_ch;
   logic [SHIFT_W-1:0]       s2_shift;
   logic [DOUT_W-1:0]        s2_zp;

   logic                     s3_valid;
   logic signed [RW-1:0]     s3_r;
   logic [CH_W-1:0]          s3_ch;

   // Multiply
   logic signed [PW-1:0] prod;
   assign prod = PW'(s1_din) * PW'($signed({1'b0, s1_m0}));

   // Rounding shift and zero-point add
   logic signed [RW-1:0] bias;
   logic signed [RW-1:0] q;
   logic signed [RW-1:0] r;

   always_comb begin
`ifdef QUAN_ROUND_EN
      bias = (s2_shift != '0) ? (RW'(1) <<< (s2_shift - SHIFT_W'(1))) : '0;
`else
      bias = '0;
`endif
      q = (RW'(s2_p) + bias) >>> s2_shift;
      r = q + RW'($signed({1'b0, s2_zp}));
   end

   // Saturation to the unsigned output range
   logic [DOUT_W-1:0] sat_val;
   logic              sat_flag;

   always_comb begin
      sat_val  = s3_r[DOUT_W-1:0];
      sat_flag = 1'b0;
      if (s3_r[RW-1]) begin
         sat_val  = '0;
         sat_flag = 1'b1;
      end else if (s3_r > MAXV) begin
         sat_val  = '1;
         sat_flag = 1'b1;
      end
   end

   // Data registers only load on a valid beat so bubbles leave them untouched;
   // this keeps dout at its reset value until the first real result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_din    <= '0;
         s1_ch     <= '0;
         s1_m0     <= '0;
         s1_shift  <= '0;
         s1_zp     <= '0;
         s2_valid  <= 1'b0;
         s2_p      <= '0;
         s2_ch     <= '0;
         s2_shift  <= '0;
         s2_zp     <= '0;
         s3_valid  <= 1'b0;
         s3_r      <= '0;
         s3_ch     <= '0;
         out_valid <= 1'b0;
         dout      <= '0;
         dout_ch   <= '0;
         dout_sat  <= 1'b0;
      end else if (adv) begin
         s1_valid  <= in_valid;
         s2_valid  <= s1_valid;
         s3_valid  <= s2_valid;
         out_valid <= s3_valid;
         if (in_valid) begin
            s1_din   <= $signed(din);
            s1_ch    <= din_ch;
            s1_m0    <= m0_sel;
            s1_shift <= shift_sel;
            s1_zp    <= zp_sel;
         end
         if (s1_valid) begin
            s2_p     <= prod;
            s2_ch    <= s1_ch;
            s2_shift <= s1_shift;
            s2_zp    <= s1_zp;
         end
         if (s2_valid) begin
            s3_r  <= r;
            s3_ch <= s2_ch;
         end
         if (s3_valid) begin
            dout     <= sat_val;
            dout_ch  <= s3_ch;
            dout_sat <= sat_flag;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_quan_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_quan_pipe
//  Purpose  : Scoreboard bench for quan_pipe. The driver pushes the
//             hand-computed result of every accepted beat; a monitor pops and
//             compares whenever the DUT hands a result downstream.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_quan_pipe;

`ifdef QUAN_ROUND_EN
   localparam bit RND = 1'b1;
`else
   localparam bit RND = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_we;
   logic [1:0]  cfg_ch;
   logic [15:0] cfg_m0;
   logic [3:0]  cfg_shift;
   logic [7:0]  cfg_zp;
   logic        in_valid;
   logic        in_ready;
   logic [17:0] din;
   logic [1:0]  din_ch;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  dout;
   logic [1:0]  dout_ch;
   logic        dout_sat;

   quan_pipe dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_we    (cfg_we),
      .cfg_ch    (cfg_ch),
      .cfg_m0    (cfg_m0),
      .cfg_shift (cfg_shift),
      .cfg_zp    (cfg_zp),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .din       (din),
      .din_ch    (din_ch),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dout      (dout),
      .dout_ch   (dout_ch),
      .dout_sat  (dout_sat)
   );

   always #5 clk = ~clk;

   typedef struct {
      int d;
      int ch;
      int sat;
      bit lat;
      int acc;
   } exp_t;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && !out_ready) begin
            chk("stall_in_ready", int'(in_ready), 0);
            if (sb.size() > 0) begin
               chk("stall_dout", int'(dout), sb[0].d);
               chk("stall_ch", int'(dout_ch), sb[0].ch);
            end
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_beat", int'(dout), -1);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("dout", int'(dout), e.d);
               chk("dout_ch", int'(dout_ch), e.ch);
               chk("dout_sat", int'(dout_sat), e.sat);
               if (e.lat) chk("latency", cyc - e.acc, 3);
            end
         end
      end
   end

   // All stimulus tasks start and end 1 time unit after a rising edge.
   task automatic cfg(input int ch, input int m0, input int sh, input int zp);
      cfg_we    = 1'b1;
      cfg_ch    = 2'(ch);
      cfg_m0    = 16'(m0);
      cfg_shift = 4'(sh);
      cfg_zp    = 8'(zp);
      @(posedge clk); #1;
      cfg_we    = 1'b0;
   endtask

   task automatic send(input int d, input int ch, input int ed, input int es, input bit lat);
      bit got;
      exp_t e;
      got      = 1'b0;
      din      = 18'(d);
      din_ch   = 2'(ch);
      in_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready) begin
            e.d = ed; e.ch = ch; e.sat = es; e.lat = lat; e.acc = cyc + 1;
            sb.push_back(e);
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         chk("accept_timeout", 0, 1);
         in_valid = 1'b0;
         @(posedge clk); #1;
      end else begin
         @(posedge clk); #1;
         in_valid = 1'b0;
         cfg_we   = 1'b0;
      end
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         if (sb.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) chk("drain_timeout", sb.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_m0 = '0; cfg_shift = '0;
      cfg_zp = '0; in_valid = 1'b0; din = '0; din_ch = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state
      @(negedge clk);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_dout", int'(dout), 0);
      chk("rst_dout_ch", int'(dout_ch), 0);
      chk("rst_dout_sat", int'(dout_sat), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      @(posedge clk); #1;

      cfg(0, 1, 5, 1);
      cfg(1, 3, 4, 5);
      cfg(2, 1, 4, 128);
      cfg(3, 2, 1, 0);

      // Saturation both ways, rounding cases, latency
      send(-70718, 0, 0, 1, 1'b1);
      send(27586, 0, 255, 1, 1'b1);
      send(1000, 1, RND ? 193 : 192, 0, 1'b1);
      send(-40, 2, RND ? 126 : 125, 0, 1'b1);
      drain();

      // Backpressure: out_ready low for four cycles mid-stream
      fork
         begin
            send(320, 0, 11, 0, 1'b0);
            send(160, 1, 35, 0, 1'b0);
            send(64, 2, 132, 0, 1'b0);
            send(77, 3, 77, 0, 1'b0);
            send(-32, 0, 0, 0, 1'b0);
            send(-16, 1, 2, 0, 1'b0);
            send(0, 2, 128, 0, 1'b0);
            send(300, 3, 255, 1, 1'b0);
         end
         begin
            repeat (4) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (4) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();

      // Config write racing an accept on the same channel
      cfg_we = 1'b1; cfg_ch = 2'd1; cfg_m0 = 16'd3; cfg_shift = 4'd4; cfg_zp = 8'd10;
      send(1000, 1, RND ? 193 : 192, 0, 1'b1);
      send(1000, 1, RND ? 198 : 197, 0, 1'b1);
      drain();

      // Reset with three beats in flight
      send(5, 0, 0, 0, 1'b0);
      send(6, 1, 0, 0, 1'b0);
      send(7, 2, 0, 0, 1'b0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      sb.delete();
      @(negedge clk);
      chk("midrst_out_valid", int'(out_valid), 0);
      chk("midrst_dout", int'(dout), 0);
      chk("midrst_in_ready", int'(in_ready), 1);
      repeat (6) @(posedge clk);
      #1;
      send(50, 1, 50, 0, 1'b1);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
